// File: rtl/y86_pkg.sv
// y86_pkg: shared definitions for the Y86 data-memory controller.
//   - icode constants for the memory-stage instructions
//   - state_t : sequencing FSM states (IDLE, ISSUE, WAIT, RESP)
//   - req_t   : requester identity used by the round-robin arbiter
package y86_pkg;

  localparam logic [3:0] I_RMMOVQ = 4'd4;
  localparam logic [3:0] I_MRMOVQ = 4'd5;
  localparam logic [3:0] I_CALL   = 4'd8;
  localparam logic [3:0] I_RET    = 4'd9;
  localparam logic [3:0] I_PUSHQ  = 4'd10;
  localparam logic [3:0] I_POPQ   = 4'd11;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  typedef enum logic {REQ_CPU, REQ_LD} req_t;

endpackage

// File: rtl/dmem_ctrl_if.sv
// dmem_ctrl_if: bus between the controller and the single-port data memory.
//   mem_req   one-cycle access strobe
//   mem_we    write enable, qualified by mem_req
//   mem_addr  word address (AW bits)
//   mem_wdata write data
//   mem_rdata read data, valid a fixed latency after mem_req
// Modports: master = controller side, slave = memory side.
interface dmem_ctrl_if #(
  parameter int AW = 10
);
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [63:0]   mem_wdata;
  logic [63:0]   mem_rdata;

  modport master (output mem_req, mem_we, mem_addr, mem_wdata, input mem_rdata);
  modport slave  (input mem_req, mem_we, mem_addr, mem_wdata, output mem_rdata);
endinterface

// File: rtl/dmem_ctrl_decode.sv
// dmem_decode: combinational decode of the M-stage icode.
//   icode, val_a, val_e, val_p in
//   is_access : icode touches memory
//   is_write  : access is a store
//   addr      : low AW bits of the selected (ValA or ValE) address
//   wdata     : store data (ValA or ValP), zero for loads
//   addr_err  : selected address is negative or >= DEPTH
module dmem_decode
  import y86_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic [3:0]    icode,
  input  logic [63:0]   val_a,
  input  logic [63:0]   val_e,
  input  logic [63:0]   val_p,
  output logic          is_access,
  output logic          is_write,
  output logic [AW-1:0] addr,
  output logic [63:0]   wdata,
  output logic          addr_err
);

  logic [63:0] sel_addr;

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case leaves a value unassigned and infers a latch.
  always_comb begin
    is_access = 1'b1;
    is_write  = 1'b0;
    sel_addr  = val_e;
    wdata     = '0;
    case (icode)
      I_RMMOVQ: begin is_write = 1'b1; wdata = val_a; end
      I_MRMOVQ: begin end
      I_CALL:   begin is_write = 1'b1; wdata = val_p; end
      I_RET:    sel_addr = val_a;
      I_PUSHQ:  begin is_write = 1'b1; wdata = val_a; end
      I_POPQ:   sel_addr = val_a;
      default:  is_access = 1'b0;
    endcase
  end

  assign addr = sel_addr[AW-1:0];
  // Address is signed: the sign bit alone flags negatives, the unsigned
  // compare catches the positive overflow.
  assign addr_err = is_access && (sel_addr[63] || (sel_addr >= 64'(DEPTH)));

endmodule

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: sequencing controller for the single-port DEPTHx64 data memory.
// Arbitrates round-robin between the CPU M stage and a loader port, runs
// each access through IDLE -> ISSUE -> WAIT -> RESP, bounds-checks CPU
// addresses and stalls the CPU until its access completes.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   m_*                 CPU M-stage request / m_stall, m_done, m_valM, dmem_err
//   ld_*                loader request (held until ld_done) / ld_done, ld_rdata
//   mem                 dmem_ctrl_if.master toward the memory
// Optional: define DMEM_PERF_EN to add perf_acc (completed valid CPU
// accesses) and perf_stall (stalled cycles), both saturating 32-bit.
module dmem_ctrl
  import y86_pkg::*;
#(
  parameter int DEPTH   = 1024,
  parameter int AW      = 10,
  parameter int MEM_LAT = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m_valid,
  input  logic [3:0]    m_icode,
  input  logic [63:0]   m_valA,
  input  logic [63:0]   m_valE,
  input  logic [63:0]   m_valP,
  output logic          m_stall,
  output logic          m_done,
  output logic [63:0]   m_valM,
  output logic          dmem_err,
  input  logic          ld_req,
  input  logic          ld_we,
  input  logic [AW-1:0] ld_addr,
  input  logic [63:0]   ld_wdata,
  output logic          ld_done,
  output logic [63:0]   ld_rdata,
  dmem_ctrl_if.master   mem
`ifdef DMEM_PERF_EN
  ,
  output logic [31:0]   perf_acc,
  output logic [31:0]   perf_stall
`endif
);

  localparam int CW = $clog2(MEM_LAT + 1);

  logic          dec_is_access, dec_is_write, dec_addr_err;
  logic [AW-1:0] dec_addr;
  logic [63:0]   dec_wdata;

  dmem_decode #(.DEPTH(DEPTH), .AW(AW)) u_decode (
    .icode    (m_icode),
    .val_a    (m_valA),
    .val_e    (m_valE),
    .val_p    (m_valP),
    .is_access(dec_is_access),
    .is_write (dec_is_write),
    .addr     (dec_addr),
    .wdata    (dec_wdata),
    .addr_err (dec_addr_err)
  );

  logic cpu_req, grant_cpu;
  assign cpu_req = m_valid && dec_is_access;

  state_t        state_q, state_d;
  req_t          owner_q, owner_d, last_grant_q, last_grant_d;
  logic          err_q, err_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [63:0]   mem_wdata_q, mem_wdata_d;
  logic          m_done_q, m_done_d, ld_done_q, ld_done_d;
  logic          dmem_err_q, dmem_err_d;
  logic [63:0]   m_valM_q, m_valM_d, ld_rdata_q, ld_rdata_d;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    err_d        = err_q;
    cnt_d        = cnt_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    m_valM_d     = m_valM_q;
    ld_rdata_d   = ld_rdata_q;
    grant_cpu    = 1'b0;
    // Strobes and completion pulses last exactly one cycle.
    mem_req_d    = 1'b0;
    m_done_d     = 1'b0;
    ld_done_d    = 1'b0;
    dmem_err_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cpu_req || ld_req) begin
          // On a tie the requester that did not win last time goes first.
          grant_cpu = cpu_req && (!ld_req || (last_grant_q == REQ_LD));
          owner_d   = grant_cpu ? REQ_CPU : REQ_LD;
          if (grant_cpu) begin
            mem_we_d    = dec_is_write;
            mem_addr_d  = dec_addr;
            mem_wdata_d = dec_wdata;
            err_d       = dec_addr_err;
          end else begin
            mem_we_d    = ld_we;
            mem_addr_d  = ld_addr;
            mem_wdata_d = ld_wdata;
            err_d       = 1'b0;
          end
          // Registered strobe: high during ISSUE, never for a bad address.
          mem_req_d = !err_d;
          state_d   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (err_q) begin
          // Only CPU accesses can fail the bounds check.
          m_done_d   = 1'b1;
          dmem_err_d = 1'b1;
          m_valM_d   = '0;
          state_d    = S_RESP;
        end else begin
          cnt_d   = CW'(MEM_LAT - 1);
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          if (owner_q == REQ_CPU) begin
            m_done_d = 1'b1;
            if (!mem_we_q) m_valM_d = mem.mem_rdata;
          end else begin
            ld_done_d = 1'b1;
            if (!mem_we_q) ld_rdata_d = mem.mem_rdata;
          end
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_RESP: begin
        last_grant_d = owner_q;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      owner_q      <= REQ_CPU;
      last_grant_q <= REQ_LD;
      err_q        <= 1'b0;
      cnt_q        <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      m_done_q     <= 1'b0;
      ld_done_q    <= 1'b0;
      dmem_err_q   <= 1'b0;
      m_valM_q     <= '0;
      ld_rdata_q   <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      err_q        <= err_d;
      cnt_q        <= cnt_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      m_done_q     <= m_done_d;
      ld_done_q    <= ld_done_d;
      dmem_err_q   <= dmem_err_d;
      m_valM_q     <= m_valM_d;
      ld_rdata_q   <= ld_rdata_d;
    end
  end

  // A valid instruction that does not touch memory completes immediately.
  assign m_done   = m_done_q || (m_valid && !dec_is_access);
  assign m_stall  = cpu_req && !m_done;
  assign m_valM   = m_valM_q;
  assign dmem_err = dmem_err_q;
  assign ld_done  = ld_done_q;
  assign ld_rdata = ld_rdata_q;

  assign mem.mem_req   = mem_req_q;
  assign mem.mem_we    = mem_we_q;
  assign mem.mem_addr  = mem_addr_q;
  assign mem.mem_wdata = mem_wdata_q;

`ifdef DMEM_PERF_EN
  logic [31:0] perf_acc_q, perf_acc_d, perf_stall_q, perf_stall_d;

  always_comb begin
    perf_acc_d   = perf_acc_q;
    perf_stall_d = perf_stall_q;
    if (m_done_q && !dmem_err_q && (perf_acc_q != '1)) perf_acc_d = perf_acc_q + 32'd1;
    if (m_stall && (perf_stall_q != '1)) perf_stall_d = perf_stall_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_acc_q   <= '0;
      perf_stall_q <= '0;
    end else begin
      perf_acc_q   <= perf_acc_d;
      perf_stall_q <= perf_stall_d;
    end
  end

  assign perf_acc   = perf_acc_q;
  assign perf_stall = perf_stall_q;
`endif

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: self-checking bench for dmem_ctrl with a fixed-latency memory
// responder and a reference model of the memory contents and controller rules.
module tb_dmem_ctrl;
  import y86_pkg::*;

  localparam int DEPTH   = 1024;
  localparam int AW      = 10;
  localparam int MEM_LAT = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          m_valid;
  logic [3:0]    m_icode;
  logic [63:0]   m_valA, m_valE, m_valP;
  logic          m_stall, m_done, dmem_err;
  logic [63:0]   m_valM;
  logic          ld_req, ld_we, ld_done;
  logic [AW-1:0] ld_addr;
  logic [63:0]   ld_wdata, ld_rdata;
`ifdef DMEM_PERF_EN
  logic [31:0]   perf_acc, perf_stall;
`endif

  always #5 clk = ~clk;

  dmem_ctrl_if #(.AW(AW)) mem_bus ();

  dmem_ctrl #(.DEPTH(DEPTH), .AW(AW), .MEM_LAT(MEM_LAT)) dut (
    .clk(clk), .rst(rst),
    .m_valid(m_valid), .m_icode(m_icode), .m_valA(m_valA), .m_valE(m_valE), .m_valP(m_valP),
    .m_stall(m_stall), .m_done(m_done), .m_valM(m_valM), .dmem_err(dmem_err),
    .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .ld_done(ld_done), .ld_rdata(ld_rdata),
    .mem(mem_bus)
`ifdef DMEM_PERF_EN
    , .perf_acc(perf_acc), .perf_stall(perf_stall)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Power-on contents of any word never written.
  function automatic logic [63:0] init_val(input int a);
    return {32'hC0DE_0000 | 32'(a), 32'(a) * 32'h9E37_79B9};
  endfunction

  // ---------------- memory responder ----------------
  logic [63:0] phys_mem [DEPTH];
  bit          phys_wr  [DEPTH];
  logic [63:0] pipe_d   [MEM_LAT];
  bit          pipe_v   [MEM_LAT];
  logic [63:0] noise;
  int          req_cnt = 0;
  logic        last_we;
  logic [AW-1:0] last_addr;
  logic [63:0] last_wdata;

  always @(posedge clk) begin
    noise <= {$urandom, $urandom};
    pipe_v[0] <= mem_bus.mem_req && !mem_bus.mem_we;
    pipe_d[0] <= phys_wr[mem_bus.mem_addr] ? phys_mem[mem_bus.mem_addr] : init_val(int'(mem_bus.mem_addr));
    for (int i = 1; i < MEM_LAT; i++) begin
      pipe_v[i] <= pipe_v[i-1];
      pipe_d[i] <= pipe_d[i-1];
    end
    if (mem_bus.mem_req) begin
      req_cnt    <= req_cnt + 1;
      last_we    <= mem_bus.mem_we;
      last_addr  <= mem_bus.mem_addr;
      last_wdata <= mem_bus.mem_wdata;
      if (mem_bus.mem_we) begin
        phys_mem[mem_bus.mem_addr] <= mem_bus.mem_wdata;
        phys_wr[mem_bus.mem_addr]  <= 1'b1;
      end
    end
  end

  // Data is only meaningful MEM_LAT cycles after a read strobe; noise otherwise.
  always_comb mem_bus.mem_rdata = pipe_v[MEM_LAT-1] ? pipe_d[MEM_LAT-1] : noise;

`ifdef DMEM_PERF_EN
  int stall_cyc = 0, acc_cnt = 0;
  always @(posedge clk) begin
    if (rst) begin
      stall_cyc <= 0;
      acc_cnt   <= 0;
    end else begin
      if (m_stall) stall_cyc <= stall_cyc + 1;
      if (m_done && !dmem_err && m_valid && (m_icode inside {4, 5, 8, 9, 10, 11})) acc_cnt <= acc_cnt + 1;
    end
  end
`endif

  // ---------------- reference model ----------------
  logic [63:0] ref_mem [int];
  logic [63:0] exp_valM;

  function automatic logic [63:0] ref_read(input int a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction

  // What an M-stage instruction asks of memory.
  function automatic void cpu_expect(input logic [3:0] ic, input logic [63:0] a, e, p,
                                     output bit acc, wr, err, output int addr,
                                     output logic [63:0] data);
    longint sa;
    acc = 1; wr = 0; sa = longint'(e); data = '0;
    case (ic)
      4'd4:    begin wr = 1; data = a; end
      4'd5:    ;
      4'd8:    begin wr = 1; data = p; end
      4'd9:    sa = longint'(a);
      4'd10:   begin wr = 1; data = a; end
      4'd11:   sa = longint'(a);
      default: acc = 0;
    endcase
    err  = acc && (sa < 0 || sa >= DEPTH);
    addr = err ? 0 : int'(sa);
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1; m_valid = 0; ld_req = 0;
    @(negedge clk);
    rst = 0;
    exp_valM = '0;
  endtask

  task automatic do_cpu(input string tag, input logic [3:0] ic, input logic [63:0] a, e, p);
    bit acc, wr, err, done, stall_bad;
    int addr, k, start, exp_lat;
    logic [63:0] data;
    cpu_expect(ic, a, e, p, acc, wr, err, addr, data);
    @(negedge clk);
    m_valid = 1; m_icode = ic; m_valA = a; m_valE = e; m_valP = p;
    #1;
    start = req_cnt;
    if (!acc) begin
      check({tag, ".done_now"}, m_done, 1);
      check({tag, ".no_stall"}, m_stall, 0);
      check({tag, ".valM_kept"}, m_valM, exp_valM);
      m_valid = 0;
      repeat (2) @(negedge clk);
      #1;
      check({tag, ".no_req"}, 64'(req_cnt - start), 0);
      return;
    end
    exp_lat = err ? 2 : MEM_LAT + 2;
    k = 0; done = 0; stall_bad = 0;
    while (!done && k <= 20) begin
      if (m_done === 1'b1) done = 1;
      else begin
        if (m_stall !== 1'b1) stall_bad = 1;
        @(negedge clk); #1; k++;
      end
    end
    check({tag, ".done_seen"}, 64'(done), 1);
    check({tag, ".latency"}, 64'(k), 64'(exp_lat));
    check({tag, ".stall"}, 64'(stall_bad), 0);
    check({tag, ".err"}, dmem_err, err);
    check({tag, ".req_cnt"}, 64'(req_cnt - start), err ? 0 : 1);
    if (err) begin
      exp_valM = '0;
    end else begin
      check({tag, ".mem_we"}, last_we, wr);
      check({tag, ".mem_addr"}, 64'(last_addr), 64'(addr));
      check({tag, ".addr_held"}, 64'(mem_bus.mem_addr), 64'(addr));
      if (wr) begin
        check({tag, ".mem_wdata"}, last_wdata, data);
        ref_mem[addr] = data;
      end else begin
        exp_valM = ref_read(addr);
      end
    end
    check({tag, ".valM"}, m_valM, exp_valM);
    m_valid = 0;
  endtask

  task automatic do_ld(input string tag, input bit we, input int a, input logic [63:0] d);
    bit done;
    int k, start;
    @(negedge clk);
    ld_req = 1; ld_we = we; ld_addr = AW'(a); ld_wdata = d;
    #1;
    start = req_cnt; k = 0; done = 0;
    while (!done && k <= 20) begin
      if (ld_done === 1'b1) done = 1;
      else begin @(negedge clk); #1; k++; end
    end
    check({tag, ".done_seen"}, 64'(done), 1);
    check({tag, ".latency"}, 64'(k), 64'(MEM_LAT + 2));
    check({tag, ".req_cnt"}, 64'(req_cnt - start), 1);
    check({tag, ".mem_addr"}, 64'(last_addr), 64'(a));
    check({tag, ".mem_we"}, last_we, we);
    if (we) begin
      check({tag, ".mem_wdata"}, last_wdata, d);
      ref_mem[a] = d;
    end else begin
      check({tag, ".rdata"}, ld_rdata, ref_read(a));
    end
    ld_req = 0;
  endtask

  function automatic logic [63:0] pick_addr();
    case ($urandom_range(0, 7))
      0:       return 64'd0;
      1:       return 64'(DEPTH - 1);
      2:       return 64'(DEPTH);
      3:       return '1;
      4:       return {1'b1, 31'($urandom), 32'($urandom)};
      5:       return {32'($urandom), 32'($urandom)};
      default: return 64'($urandom_range(0, DEPTH - 1));
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int cpu_k[$], ld_k[$], start;
    bit stall_ld;
    logic [3:0] ic;

    rst = 1; m_valid = 0; m_icode = 0; m_valA = 0; m_valE = 0; m_valP = 0;
    ld_req = 0; ld_we = 0; ld_addr = 0; ld_wdata = 0; exp_valM = '0;
    repeat (2) @(negedge clk);
    rst = 0;
    #1;
    check("rst.m_stall", m_stall, 0);
    check("rst.m_done", m_done, 0);
    check("rst.m_valM", m_valM, 0);
    check("rst.dmem_err", dmem_err, 0);
    check("rst.ld_done", ld_done, 0);
    check("rst.ld_rdata", ld_rdata, 0);
    check("rst.mem_req", mem_bus.mem_req, 0);
    check("rst.mem_we", mem_bus.mem_we, 0);
    check("rst.mem_addr", 64'(mem_bus.mem_addr), 0);
    check("rst.mem_wdata", mem_bus.mem_wdata, 0);

    // Directed: store, load back, bounds errors, no-access instruction.
    do_cpu("rmmovq", 4'd4, 64'hAB, 64'd16, 64'd0);
    do_cpu("mrmovq", 4'd5, 64'd0, 64'd16, 64'd0);
    check("mrmovq.value", m_valM, 64'hAB);
    do_cpu("popq_neg", 4'd11, -64'sd8, 64'd0, 64'd0);
    do_cpu("popq_1024", 4'd11, 64'd1024, 64'd0, 64'd0);
    do_cpu("pushq_last", 4'd10, 64'h1234_5678, 64'd1023, 64'd0);
    do_cpu("ret_last", 4'd9, 64'd1023, 64'd0, 64'd0);
    do_cpu("call", 4'd8, 64'd0, 64'd40, 64'hCAFE);
    do_cpu("noacc", 4'd0, 64'd5, 64'd5, 64'd5);

    // Contention from reset: CPU first, then alternation while both held.
    do_reset();
    @(negedge clk);
    m_valid = 1; m_icode = 4'd9; m_valA = 64'd100; m_valE = 0; m_valP = 0;
    ld_req = 1; ld_we = 0; ld_addr = AW'(200); ld_wdata = 0;
    #1;
    stall_ld = 0;
    for (int k = 0; k <= 24; k++) begin
      if (m_done === 1'b1) begin
        cpu_k.push_back(k);
        check("arb.cpu_valM", m_valM, ref_read(100));
      end
      if (ld_done === 1'b1) begin
        ld_k.push_back(k);
        check("arb.ld_rdata", ld_rdata, ref_read(200));
      end
      if (k == 6) stall_ld = m_stall;
      if (k < 24) begin @(negedge clk); #1; end
    end
    m_valid = 0; ld_req = 0;
    exp_valM = ref_read(100);
    check("arb.stall_ld_owner", 64'(stall_ld), 1);
    check("arb.cpu_count", 64'(cpu_k.size()), 3);
    check("arb.ld_count", 64'(ld_k.size()), 2);
    if (cpu_k.size() == 3 && ld_k.size() == 2) begin
      check("arb.cpu0", 64'(cpu_k[0]), 4);
      check("arb.ld0", 64'(ld_k[0]), 9);
      check("arb.cpu1", 64'(cpu_k[1]), 14);
      check("arb.ld1", 64'(ld_k[1]), 19);
      check("arb.cpu2", 64'(cpu_k[2]), 24);
    end

    // Reset during WAIT aborts the access silently.
    @(negedge clk);
    @(negedge clk);
    m_valid = 1; m_icode = 4'd5; m_valA = 0; m_valE = 64'd50; m_valP = 0;
    #1;
    start = req_cnt;
    repeat (2) @(negedge clk);
    rst = 1; m_valid = 0;
    @(negedge clk);
    rst = 0;
    #1;
    exp_valM = '0;
    check("abort.m_done", m_done, 0);
    check("abort.m_valM", m_valM, 0);
    check("abort.dmem_err", dmem_err, 0);
    check("abort.mem_req", mem_bus.mem_req, 0);
    check("abort.mem_addr", 64'(mem_bus.mem_addr), 0);
    begin
      bit any_done = 0;
      for (int k = 0; k < 5; k++) begin
        if (m_done === 1'b1 || ld_done === 1'b1) any_done = 1;
        @(negedge clk); #1;
      end
      check("abort.no_done", 64'(any_done), 0);
    end
    check("abort.req_cnt", 64'(req_cnt - start), 1);
    do_cpu("after_abort", 4'd4, 64'h5151, 64'd77, 64'd0);
    do_cpu("after_abort_rd", 4'd5, 64'd0, 64'd77, 64'd0);

    // Randomized mix of CPU and loader traffic.
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 9) < 3) begin
        do_ld("rnd_ld", bit'($urandom_range(0, 1)), int'($urandom_range(0, DEPTH - 1)),
              {$urandom, $urandom});
      end else begin
        if ($urandom_range(0, 3) == 0) ic = 4'($urandom_range(0, 15));
        else begin
          case ($urandom_range(0, 5))
            0: ic = 4'd4; 1: ic = 4'd5; 2: ic = 4'd8;
            3: ic = 4'd9; 4: ic = 4'd10; default: ic = 4'd11;
          endcase
        end
        do_cpu("rnd_cpu", ic, pick_addr(), pick_addr(), {$urandom, $urandom});
      end
    end

`ifdef DMEM_PERF_EN
    @(negedge clk); #1;
    check("perf.stall", 64'(perf_stall), 64'(stall_cyc));
    check("perf.acc", 64'(perf_acc), 64'(acc_cnt));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
